ballot_collector: RTL and testbench
===================================

Name: ballot_collector

Overview:
- Producer side of the majority-vote datapath: runs a voting round, collecting one vote per voter over a serial valid/ready interface.
- Assembles the N-bit ballot vector `people`, which drives the `election` majority block directly.
- Rejects duplicate and out-of-range votes, closes the round when every voter has voted or a timeout expires, then presents the ballot with a one-cycle valid pulse.

Parameters:
- N_VOTERS, 7, number of voters; width of `people`, range 2..16.
- TIMEOUT, 32, max cycles spent in COLLECT before forced close, must be ≥ 2.
- ID_W, 3, vote_id width, ≥ clog2(N_VOTERS).
- CNT_W, 3, yes_count width, = clog2(N_VOTERS+1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  opens a round when sampled high in IDLE.
- vote_valid  input  1  voter presents a vote.
- vote_id  input  ID_W  voter index.
- vote_val  input  1  1 = yes, 0 = no.
- vote_ready  output  1  collector accepts a vote this cycle.
- people  output  N_VOTERS  ballot vector, bit i = vote of voter i; to election.people.
- people_valid  output  1  one-cycle pulse, ballot final.
- voted_mask  output  N_VOTERS  bit i set once voter i has voted.
- yes_count  output  CNT_W  number of accepted yes votes.
- dup_err  output  1  one-cycle pulse on rejected vote.
- timeout  output  1  sticky; round closed by timeout.
- busy  output  1  high in COLLECT and CLOSE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - people, voted_mask, yes_count and timer = 0.
  - vote_ready, people_valid, dup_err, timeout and busy = 0.
- Clock and reset convention: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
- FSM states: IDLE, COLLECT, CLOSE.
- IDLE:
  - vote_ready=0; votes are ignored.
  - start=1 → COLLECT next edge. On that edge people, voted_mask, yes_count, timer and timeout are cleared.
  - people, voted_mask and yes_count otherwise hold their last-round values.
- COLLECT:
  - vote_ready=1 and busy=1. start is ignored.
  - Accept when vote_valid && vote_ready. The update is visible on the next edge (1-cycle latency).
  - Legal vote (vote_id < N_VOTERS and voted_mask[vote_id]=0):
    - people[vote_id] ← vote_val;
    - voted_mask[vote_id] ← 1;
    - yes_count ← yes_count + vote_val.
  - Illegal vote (vote_id ≥ N_VOTERS or already voted): no state change; dup_err=1 for exactly the next cycle.
  - timer increments every COLLECT cycle, starting at 0 on entry.
  - Exit to CLOSE when the post-update mask is all ones (normal close).
  - Also exit to CLOSE when timer = TIMEOUT-1 with the mask not full; timeout←1 on that edge.
  - Simultaneous last legal vote and timer expiry: the vote is accepted, the mask becomes full, and timeout stays 0.
  - Voters that never voted keep their people bit = 0 (abstain counts as no).
- CLOSE:
  - Lasts exactly 1 cycle: people_valid=1, busy=1, vote_ready=0.
  - people and yes_count are stable. → IDLE.
- After the round, people, voted_mask, yes_count and timeout hold until the next start.
- start arriving in the CLOSE cycle is ignored; a new round needs start in IDLE.
- yes_count never exceeds N_VOTERS; there is no wrap.
- Reset asserted mid-round aborts immediately to the reset values. No people_valid pulse is generated.

Test Plan:
1. Normal round:
   - Stimulus: start, then votes id0..4 yes and id5..6 no, back-to-back.
   - Required: people=7'b0011111, yes_count=5, people_valid pulses the cycle after the 7th accept, timeout=0, election result=1.
2. Duplicate and out-of-range:
   - Stimulus: in a round, vote id2 yes, id2 no again, then id7 yes.
   - Required: two dup_err pulses; people[2]=1, voted_mask=7'b0000100, yes_count=1.
3. Timeout:
   - Stimulus: start, vote id0 yes only, then idle.
   - Required: CLOSE 32 cycles after COLLECT entry; people=7'b0000001, timeout=1, people_valid pulse; election result=0.
4. Expiry race:
   - Stimulus: six votes accepted early; the 7th legal vote accepted exactly on timer=31.
   - Required: people_valid pulse, timeout=0.
5. Reset mid-round:
   - Stimulus: rst_n low after 3 votes.
   - Required: all outputs 0 immediately (asynchronous), no people_valid; a following start and 7 votes complete normally.
6. Backpressure:
   - Stimulus: vote_valid held high in IDLE and in the CLOSE cycle.
   - Required: vote_ready=0, no mask change; start during COLLECT does not clear progress.

Source files
------------

// File: rtl/ballot_collector.sv
// ballot_collector: runs one voting round, gathering at most one vote per
// voter over a valid/ready interface, and presents the assembled ballot
// vector to the election majority block with a one-cycle valid pulse.
module ballot_collector #(
  parameter int N_VOTERS = 7,
  parameter int TIMEOUT  = 32,
  parameter int ID_W     = 3,
  parameter int CNT_W    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                vote_valid,
  input  logic [ID_W-1:0]     vote_id,
  input  logic                vote_val,
  output logic                vote_ready,
  output logic [N_VOTERS-1:0] people,
  output logic                people_valid,
  output logic [N_VOTERS-1:0] voted_mask,
  output logic [CNT_W-1:0]    yes_count,
  output logic                dup_err,
  output logic                timeout,
  output logic                busy
);

  localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CLOSE   = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [TIMER_W-1:0]  timer;
  logic [N_VOTERS-1:0] sel;
  logic [N_VOTERS-1:0] mask_post;
  logic                accept;
  logic                legal;
  logic                legal_acc;
  logic                mask_full;
  logic                expire;

  // Out-of-range ids shift the one-hot select completely out, so an empty
  // select doubles as the range check.
  always_comb begin
    sel       = N_VOTERS'(1) << vote_id;
    accept    = vote_valid && vote_ready;
    legal     = (|sel) && !(|(sel & voted_mask));
    legal_acc = accept && legal;
    mask_post = legal_acc ? (voted_mask | sel) : voted_mask;
    mask_full = &mask_post;
    // A last vote landing on the final timer cycle fills the mask and wins
    expire    = (state == COLLECT) && !mask_full && (timer == TIMER_LAST);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = COLLECT;
      COLLECT: if (mask_full || expire) state_next = CLOSE;
      CLOSE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    vote_ready   = (state == COLLECT);
    busy         = (state == COLLECT) || (state == CLOSE);
    people_valid = (state == CLOSE);
  end

  // Ballot datapath, round timer, error pulse and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      people     <= '0;
      voted_mask <= '0;
      yes_count  <= '0;
      timer      <= '0;
      timeout    <= 1'b0;
      dup_err    <= 1'b0;
    end else begin
      dup_err <= accept && !legal;
      case (state)
        IDLE: begin
          if (start) begin
            people     <= '0;
            voted_mask <= '0;
            yes_count  <= '0;
            timer      <= '0;
            timeout    <= 1'b0;
          end
        end
        COLLECT: begin
          timer <= timer + TIMER_W'(1);
          if (legal_acc) begin
            people     <= (people & ~sel) | (vote_val ? sel : '0);
            voted_mask <= mask_post;
            yes_count  <= yes_count + CNT_W'(vote_val);
          end
          if (expire) timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ballot_collector.sv
// Directed testbench for ballot_collector (N_VOTERS=7, TIMEOUT=32).
// Inputs change and outputs are checked 1ns after each rising edge.
module tb_ballot_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       vote_valid;
  logic [2:0] vote_id;
  logic       vote_val;
  logic       vote_ready;
  logic [6:0] people;
  logic       people_valid;
  logic [6:0] voted_mask;
  logic [2:0] yes_count;
  logic       dup_err;
  logic       timeout;
  logic       busy;

  int checks = 0;
  int errors = 0;

  ballot_collector #(
    .N_VOTERS(7),
    .TIMEOUT (32),
    .ID_W    (3),
    .CNT_W   (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .vote_valid  (vote_valid),
    .vote_id     (vote_id),
    .vote_val    (vote_val),
    .vote_ready  (vote_ready),
    .people      (people),
    .people_valid(people_valid),
    .voted_mask  (voted_mask),
    .yes_count   (yes_count),
    .dup_err     (dup_err),
    .timeout     (timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic vote(input int id, input logic val);
    vote_valid = 1'b1;
    vote_id    = 3'(id);
    vote_val   = val;
    step();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; vote_valid = 1'b0; vote_id = '0; vote_val = 1'b0;
    #12;
    chk("rst_people", people, 0);
    chk("rst_mask", voted_mask, 0);
    chk("rst_yes", yes_count, 0);
    chk("rst_ready", vote_ready, 0);
    chk("rst_pv", people_valid, 0);
    chk("rst_dup", dup_err, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();
    chk("idle_ready", vote_ready, 0);

    // 1. Normal round: ids 0..4 yes, 5..6 no
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_ready", vote_ready, 1);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) chk("t1_pv_early", people_valid, 0);
      vote(i, i < 5);
    end
    chk("t1_pv", people_valid, 1);
    chk("t1_people", people, 7'b0011111);
    chk("t1_yes", yes_count, 5);
    chk("t1_timeout", timeout, 0);
    chk("t1_close_ready", vote_ready, 0);
    chk("t1_close_busy", busy, 1);
    // 6. Backpressure: vote and start held in CLOSE, then vote held in IDLE
    vote_id = 3'd0; vote_val = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_idle_pv", people_valid, 0);
    chk("t6_start_in_close", busy, 0);
    chk("t6_close_dup", dup_err, 0);
    chk("t6_close_people", people, 7'b0011111);
    step();
    chk("t6_idle_ready", vote_ready, 0);
    chk("t6_idle_mask", voted_mask, 7'h7f);
    chk("t6_idle_yes", yes_count, 5);
    vote_valid = 1'b0;

    // 2. Duplicate and out-of-range
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t2_clr_mask", voted_mask, 0);
    chk("t2_clr_people", people, 0);
    chk("t2_clr_yes", yes_count, 0);
    vote(2, 1'b1);
    chk("t2_mask1", voted_mask, 7'b0000100);
    chk("t2_dup0", dup_err, 0);
    vote(2, 1'b0);
    chk("t2_dup1", dup_err, 1);
    vote(7, 1'b1);
    chk("t2_dup2", dup_err, 1);
    chk("t2_mask_oor", voted_mask, 7'b0000100);
    vote_valid = 1'b0;
    step();
    chk("t2_dup_clear", dup_err, 0);
    chk("t2_people", people, 7'b0000100);
    chk("t2_yes", yes_count, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_start_in_collect", voted_mask, 7'b0000100);
    chk("t6_busy_in_collect", busy, 1);
    for (int k = 0; k < 40 && !people_valid; k++) step();
    chk("t2_close", people_valid, 1);
    chk("t2_timeout", timeout, 1);
    step();

    // 3. Timeout: CLOSE 32 cycles after COLLECT entry
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_timeout_clr", timeout, 0);
    vote(0, 1'b1);
    vote_valid = 1'b0;
    for (int k = 0; k < 30; k++) step();
    chk("t3_last_busy", busy, 1);
    chk("t3_last_pv", people_valid, 0);
    chk("t3_last_to", timeout, 0);
    step();
    chk("t3_pv", people_valid, 1);
    chk("t3_timeout", timeout, 1);
    chk("t3_people", people, 7'b0000001);
    chk("t3_yes", yes_count, 1);
    step();
    chk("t3_sticky", timeout, 1);
    chk("t3_idle_pv", people_valid, 0);

    // 4. Expiry race: 7th legal vote on the final timer cycle
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) vote(i, 1'b1);
    vote_valid = 1'b0;
    for (int k = 0; k < 25; k++) step();
    chk("t4_pre_busy", busy, 1);
    chk("t4_pre_pv", people_valid, 0);
    vote(6, 1'b1);
    vote_valid = 1'b0;
    chk("t4_pv", people_valid, 1);
    chk("t4_timeout", timeout, 0);
    chk("t4_people", people, 7'h7f);
    chk("t4_yes", yes_count, 7);
    step();

    // 5. Reset mid-round
    start = 1'b1;
    step();
    start = 1'b0;
    vote(0, 1'b1);
    vote(1, 1'b1);
    vote(2, 1'b1);
    vote_id = 3'd3;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_people", people, 0);
    chk("t5_mask", voted_mask, 0);
    chk("t5_yes", yes_count, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", vote_ready, 0);
    step();
    chk("t5_no_pv", people_valid, 0);
    rst_n = 1'b1;
    vote_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) vote(i, (i % 2) == 1);
    vote_valid = 1'b0;
    chk("t5_pv", people_valid, 1);
    chk("t5_people_after", people, 7'b0101010);
    chk("t5_yes_after", yes_count, 3);
    chk("t5_timeout", timeout, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
